// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART: parity encodings, receiver FSM
// state encodings and the oversample tick divider calculation.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: clock divider plus tick index, restartable so the
// sampling phase can be aligned to an incoming edge.
module uart_os_tick #(
    parameter int unsigned DIV        = 26,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_restart,
    output logic                          o_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_idx
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned IW = $clog2(OVERSAMPLE);

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            cnt   <= '0;
            o_idx <= '0;
        end else if (o_tick) begin
            cnt   <= '0;
            o_idx <= (o_idx == IW'(OVERSAMPLE - 1)) ? '0 : o_idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable data width, parity and stop bits;
// reports parity/frame errors and line breaks alongside a one-cycle data strobe.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 48000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned IW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [IW-1:0] T_A = IW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] T_B = IW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0] T_C = IW'(OVERSAMPLE / 2 + 1);

    if (DIV < 2 || OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_os: unsupported parameter set");
    end

    logic                 rx_meta;
    logic                 rx_sync;
    logic [2:0]           state;
    logic                 tick;
    logic [IW-1:0]        idx;
    logic                 restart;
    logic                 samp_a;
    logic                 samp_b;
    logic                 vote;
    logic                 vote_tick;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_low;
    logic                 par_bit;
    logic                 par_calc;
    logic                 par_err;
    logic                 fe_now;
    logic                 brk_now;
    logic                 armed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // Only a disarmed receiver (after a break) ignores a low line in IDLE.
    assign restart = (state == ST_IDLE) && !rx_sync && armed;

    uart_os_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (restart),
        .o_tick    (tick),
        .o_idx     (idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick && idx == T_A) begin
            samp_a <= rx_sync;
        end else if (tick && idx == T_B) begin
            samp_b <= rx_sync;
        end
    end

    assign vote_tick = tick && (idx == T_C);
    assign vote      = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign o_busy    = (state != ST_IDLE);

    always_comb begin
        par_calc = (^shreg) ^ par_bit;
        par_err  = 1'b0;
        if (PARITY == PAR_ODD) begin
            par_err = !par_calc;
        end else if (PARITY == PAR_EVEN) begin
            par_err = par_calc;
        end
        fe_now  = stop_low | ~vote;
        brk_now = fe_now && (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit);
    end

    // Each state consumes the next mid-bit vote, so transitions happen mid-bit
    // and the frame completes at the last stop vote rather than at its bit end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            stop_low     <= 1'b0;
            par_bit      <= 1'b0;
            armed        <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick && rx_sync) begin
                        armed <= 1'b1;
                    end
                    if (restart) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (vote_tick) begin
                        if (!vote) begin
                            state    <= ST_DATA;
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            stop_low <= 1'b0;
                            par_bit  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (vote_tick) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_tick) begin
                        par_bit <= vote;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (vote_tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            o_data       <= shreg;
                            o_parity_err <= par_err;
                            o_frame_err  <= fe_now;
                            o_break      <= brk_now;
                            o_valid      <= 1'b1;
                            armed        <= !brk_now;
                            state        <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                            stop_low <= stop_low | ~vote;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 8N2) at 115200 baud with a
// 16x oversample divider of 8, driven by a line-level frame generator.
module tb_uart_rx_os;

    localparam int unsigned CLK_HZ = 14745600;
    localparam real         BITC   = 128.0;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } rec_t;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       pbit;
        logic       s0;
        logic       s1;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
        logic       ebrk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx    [3];
    logic [7:0] data  [3];
    logic       valid [3];
    logic       pe    [3];
    logic       fe    [3];
    logic       brk   [3];
    logic       busy  [3];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rec_t rxq  [$];
    rec_t expq [$];

    logic prev_valid    [3] = '{1'b0, 1'b0, 1'b0};
    logic prev_busy     [3] = '{1'b0, 1'b0, 1'b0};
    int   busy_len      [3] = '{0, 0, 0};
    int   last_busy_len [3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .o_data(data[0]), .o_valid(valid[0]),
        .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(brk[0]), .o_busy(busy[0]));

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .o_data(data[1]), .o_valid(valid[1]),
        .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(brk[1]), .o_busy(busy[1]));

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2)) dut_8n2 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .o_data(data[2]), .o_valid(valid[2]),
        .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(brk[2]), .o_busy(busy[2]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Output monitor: records strobes, checks single-cycle o_valid and busy fall.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i] === 1'b1) begin
                rxq.push_back('{inst: i, d: data[i], pe: pe[i], fe: fe[i], brk: brk[i]});
                chk($sformatf("valid_single[%0d]", i), 32'(prev_valid[i]), 32'd0);
                chk($sformatf("busy_fall[%0d]", i), {30'd0, prev_busy[i], busy[i]}, 32'd2);
            end
            if (busy[i] === 1'b1) begin
                busy_len[i] <= busy_len[i] + 1;
            end else if (prev_busy[i]) begin
                last_busy_len[i] <= busy_len[i];
                busy_len[i]      <= 0;
            end
            prev_valid[i] <= valid[i];
            prev_busy[i]  <= busy[i];
        end
    end

    // Reference: expected word and flags from the frame's fields.
    function automatic rec_t model(input int inst, input logic [7:0] d, input logic pbit,
                                   input logic s0, input logic s1);
        rec_t r;
        r.inst = inst;
        r.d    = d;
        r.pe   = (inst == 1) ? ((^d) != pbit) : 1'b0;
        r.fe   = !s0 || (inst == 2 && !s1);
        r.brk  = r.fe && (d == 8'h00) && (inst != 1 || !pbit);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                              input logic s0, input logic s1, input real bc);
        logic lv [12];
        int   n;
        int   t0;
        n = 0;
        lv[n++] = 1'b0;
        for (int i = 0; i < 8; i++) lv[n++] = d[i];
        if (inst == 1) lv[n++] = pbit;
        lv[n++] = s0;
        if (inst == 2) lv[n++] = s1;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            rx[inst] = lv[k];
            while (cyc < t0 + $rtoi((k + 1) * bc + 0.5)) @(negedge clk);
        end
        rx[inst] = 1'b1;
    endtask

    task automatic compare_q(input string name);
        chk({name, ":count"}, 32'(rxq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < rxq.size()) begin
                chk($sformatf("%s[%0d]:inst", name, i), 32'(rxq[i].inst), 32'(expq[i].inst));
                chk($sformatf("%s[%0d]:data", name, i), 32'(rxq[i].d), 32'(expq[i].d));
                chk($sformatf("%s[%0d]:perr", name, i), 32'(rxq[i].pe), 32'(expq[i].pe));
                chk($sformatf("%s[%0d]:ferr", name, i), 32'(rxq[i].fe), 32'(expq[i].fe));
                chk($sformatf("%s[%0d]:brk", name, i), 32'(rxq[i].brk), 32'(expq[i].brk));
            end
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk($sformatf("%s_data[%0d]", tag, i), 32'(data[i]), 32'd0);
        chk($sformatf("%s_valid[%0d]", tag, i), 32'(valid[i]), 32'd0);
        chk($sformatf("%s_perr[%0d]", tag, i), 32'(pe[i]), 32'd0);
        chk($sformatf("%s_ferr[%0d]", tag, i), 32'(fe[i]), 32'd0);
        chk($sformatf("%s_brk[%0d]", tag, i), 32'(brk[i]), 32'd0);
        chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'd0);
    endtask

    initial begin
        vec_t       tbl [11];
        logic [7:0] d;
        logic       pbit, s0, s1;
        int         inst;
        real        bc;

        //              inst data  pbit s0 s1  exp_d  pe fe brk
        tbl[0]  = '{0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 8'h3C, 0, 0, 1, 8'h3C, 0, 1, 0};
        tbl[2]  = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1};
        tbl[3]  = '{1, 8'h03, 1, 1, 1, 8'h03, 1, 0, 0};
        tbl[4]  = '{1, 8'h03, 0, 1, 1, 8'h03, 0, 0, 0};
        tbl[5]  = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0, 0};
        tbl[6]  = '{1, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1};
        tbl[7]  = '{1, 8'h00, 1, 0, 1, 8'h00, 1, 1, 0};
        tbl[8]  = '{2, 8'hA5, 0, 1, 0, 8'hA5, 0, 1, 0};
        tbl[9]  = '{2, 8'hFF, 0, 1, 1, 8'hFF, 0, 0, 0};
        tbl[10] = '{2, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1};

        for (int i = 0; i < 3; i++) rx[i] = 1'b1;
        rst = 1'b1;
        idle(4);
        for (int i = 0; i < 3; i++) chk_reset(i, "reset");
        rst = 1'b0;
        idle(50);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, BITC);
        idle(300);
        expq.push_back(model(0, 8'hA5, 1'b0, 1'b1, 1'b1));
        compare_q("a5");
        chk_range("a5_busy_len", last_busy_len[0], 1200, 1260);

        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].inst, tbl[i].d, tbl[i].pbit, tbl[i].s0, tbl[i].s1, BITC);
            idle(300);
            expq.push_back('{inst: tbl[i].inst, d: tbl[i].ed, pe: tbl[i].epe,
                             fe: tbl[i].efe, brk: tbl[i].ebrk});
            compare_q($sformatf("vec%0d", i));
        end

        // ~4 us low pulse on an idle line
        rx[0] = 1'b0;
        idle(59);
        rx[0] = 1'b1;
        idle(300);
        compare_q("glitch");
        chk_range("glitch_busy_len", last_busy_len[0], 64, 100);

        // line held low for two 8N2 frame times
        rx[2] = 1'b0;
        idle(2816);
        rx[2] = 1'b1;
        idle(400);
        expq.push_back('{inst: 2, d: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1});
        compare_q("break");

        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, BITC / 1.025);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, BITC / 1.025);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, BITC / 1.025);
        idle(300);
        expq.push_back(model(0, 8'h00, 1'b0, 1'b1, 1'b1));
        expq.push_back(model(0, 8'hFF, 1'b0, 1'b1, 1'b1));
        expq.push_back(model(0, 8'h81, 1'b0, 1'b1, 1'b1));
        compare_q("b2b");

        // reset in the middle of data bit 4
        d = 8'h5A;
        rx[0] = 1'b0;
        idle(128);
        for (int k = 0; k < 4; k++) begin
            rx[0] = d[k];
            idle(128);
        end
        rx[0] = d[4];
        idle(64);
        rst = 1'b1;
        idle(2);
        chk_reset(0, "midrst");
        rst = 1'b0;
        rx[0] = 1'b1;
        idle(600);
        compare_q("midrst_none");
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, BITC);
        idle(300);
        expq.push_back(model(0, 8'h5A, 1'b0, 1'b1, 1'b1));
        compare_q("after_rst");

        for (int n = 0; n < 16; n++) begin
            inst = $urandom_range(0, 2);
            d    = 8'($urandom);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            s0   = ($urandom_range(0, 7) != 0);
            s1   = ($urandom_range(0, 7) != 0);
            if (!s0 || (inst == 2 && !s1))
                bc = BITC;
            else
                bc = BITC * (1.0 + (real'($urandom_range(0, 50)) - 25.0) / 1000.0);
            send_frame(inst, d, pbit, s0, s1, bc);
            idle($urandom_range(150, 400));
            expq.push_back(model(inst, d, pbit, s0, s1));
            compare_q($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
